// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtraction controller.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } serial_sub_state_e;

  // Bit-index counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fs_cell.sv
// One-bit full subtractor: d = x - y - c, bo = borrow out.
module fs_cell (
  input  logic i_x,
  input  logic i_y,
  input  logic i_c,
  output logic o_d,
  output logic o_bo
);

  assign o_d  = i_x ^ i_y ^ i_c;
  assign o_bo = (~i_x & i_y) | (~(i_x ^ i_y) & i_c);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one fs_cell walks the operands LSB first, borrow held in a flop.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int              CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  serial_sub_state_e r_state;
  serial_sub_state_e w_state_nxt;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_diff_sr;
  logic             r_brw;
  logic [CW-1:0]    r_cnt;

  logic w_d;
  logic w_bo;
  logic w_accept;
  logic w_last;

  fs_cell u_cell (
    .i_x  (r_a_sr[0]),
    .i_y  (r_b_sr[0]),
    .i_c  (r_brw),
    .o_d  (w_d),
    .o_bo (w_bo)
  );

  assign w_accept = (r_state == IDLE) && req_valid;
  assign w_last   = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (req_valid)  w_state_nxt = SHIFT;
      SHIFT:   if (w_last)     w_state_nxt = DONE;
      DONE:    if (rsp_ready)  w_state_nxt = IDLE;
      default:                 w_state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, shift one bit per SHIFT cycle, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr    <= '0;
      r_b_sr    <= '0;
      r_diff_sr <= '0;
      r_brw     <= 1'b0;
      r_cnt     <= '0;
    end else if (w_accept) begin
      r_a_sr <= a;
      r_b_sr <= b;
      r_brw  <= bin;
      r_cnt  <= '0;
    end else if (r_state == SHIFT) begin
      r_a_sr    <= r_a_sr >> 1;
      r_b_sr    <= r_b_sr >> 1;
      r_diff_sr <= {w_d, r_diff_sr[WIDTH-1:1]};
      r_brw     <= w_bo;
      r_cnt     <= r_cnt + 1'b1;
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == DONE);
  assign busy      = (r_state == SHIFT) || (r_state == DONE);
  assign diff      = r_diff_sr;
  assign bout      = r_brw;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and random bench for serial_sub_ctrl (WIDTH=8).
module tb_serial_sub_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_cyc[$];

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .diff      (diff),
    .bout      (bout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && req_valid && req_ready) acc_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation end to end; hold_req keeps req_valid high with junk operands while busy.
  task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic ibin, input int stall, input bit hold_req,
                        input logic [WIDTH-1:0] exp_diff, input logic exp_bout);
    int  t;
    int  lat;
    bit  rdy_seen;
    logic [WIDTH-1:0] d0;
    logic b0;
    a = ia; b = ib; bin = ibin; req_valid = 1'b1;
    rsp_ready = (stall == 0);
    t = 0;
    while (!req_ready && t < 100) begin tick(); t++; end
    tick();
    if (hold_req) begin
      a = ~ia; b = ~ib; bin = ~ibin;
    end else begin
      req_valid = 1'b0;
    end
    lat = 0;
    rdy_seen = 1'b0;
    while (!rsp_valid && lat < 100) begin
      if (req_ready) rdy_seen = 1'b1;
      tick();
      lat++;
      if (hold_req) begin a = $urandom(); b = $urandom(); end
    end
    chk("latency", lat, WIDTH);
    chk("req_ready_busy", {31'd0, rdy_seen}, 32'd0);
    chk("diff", diff, exp_diff);
    chk("bout", bout, exp_bout);
    d0 = diff; b0 = bout;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || diff !== d0 || bout !== b0)
        chk("stall_stable", {diff, bout, rsp_valid}, {d0, b0, 1'b1});
    end
    if (stall > 0) begin
      chk("stall_held", {31'd0, rsp_valid}, 32'd1);
      rsp_ready = 1'b1;
    end
    tick();
    chk("rsp_done", {30'd0, rsp_valid, req_ready}, 32'b01);
  endtask

  task automatic run_model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                           input logic ibin, input int stall);
    logic [WIDTH:0] r;
    r = {1'b0, ia} - {1'b0, ib} - {{WIDTH{1'b0}}, ibin};
    run_op(ia, ib, ibin, stall, 1'b0, r[WIDTH-1:0], r[WIDTH]);
  endtask

  initial begin
    int t;
    #2;
    chk("rst_outputs", {req_ready, rsp_valid, busy, bout, diff},
        {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    tick();
    rst_n = 1'b1;
    tick();

    // Basic and borrow cases
    run_op(8'h05, 8'h03, 1'b0, 0, 1'b0, 8'h02, 1'b0);
    run_op(8'h00, 8'h01, 1'b0, 0, 1'b0, 8'hFF, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0, 8'hFF, 1'b1);

    // Backpressure with requests ignored while busy
    run_op(8'hA5, 8'h3C, 1'b0, 5, 1'b1, 8'h69, 1'b0);
    req_valid = 1'b0;
    tick();

    // Reset in the third SHIFT cycle
    a = 8'hFF; b = 8'h00; bin = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {req_ready, rsp_valid, busy, bout, diff},
        {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    tick();
    rst_n = 1'b1;
    tick();
    run_op(8'h80, 8'h01, 1'b0, 0, 1'b0, 8'h7F, 1'b0);

    // Back-to-back with req_valid held high
    acc_cyc.delete();
    run_op(8'h10, 8'h01, 1'b0, 0, 1'b1, 8'h0F, 1'b0);
    run_op(8'h01, 8'h02, 1'b1, 0, 1'b1, 8'hFE, 1'b1);
    run_op(8'h7F, 8'h7F, 1'b0, 0, 1'b1, 8'h00, 1'b0);
    req_valid = 1'b0;
    chk("b2b_accepts", acc_cyc.size(), 3);
    if (acc_cyc.size() >= 3) begin
      chk("b2b_gap1", acc_cyc[1] - acc_cyc[0], WIDTH + 2);
      chk("b2b_gap2", acc_cyc[2] - acc_cyc[1], WIDTH + 2);
    end
    tick();

    // Random operations with random stalls
    for (int i = 0; i < 1000; i++) begin
      run_model($urandom(), $urandom(), $urandom_range(0, 1), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
